plab5_mcore_mem_resp_cmsg_pack_queue: RTL and testbench

Parametrised successor to the single-channel memory-response control-message packer. It accepts up to `p_num_ports` independent response-control streams (type/opaque/len plus a 1-bit security domain). It round-robin arbitrates among them, packs the winner into the standard control-message layout, and buffers packed messages, each tagged with its domain and source port, in a `p_depth`-entry FIFO. A val/rdy interface drains the FIFO. It sits between per-bank memory response paths and the shared response network.

---
 rtl/plab5_mcore_mem_resp_cmsg_pack_queue.sv | 130 +++++++++++++
 tb/tb_plab5_mcore_mem_resp_cmsg_pack_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_resp_cmsg_pack_queue.sv
// Multi-port memory-response control-message packer: round-robin arbitration,
// packing, and a domain/port-tagged FIFO drained through a val/rdy interface.
module plab5_mcore_mem_resp_cmsg_pack_queue #(
   parameter int  p_opaque_nbits = 8,
   parameter int  p_data_nbits   = 32,
   parameter int  p_num_ports    = 2,
   parameter int  p_depth        = 4,
   localparam int p_len_nbits    = $clog2(p_data_nbits/8),
   localparam int p_id_nbits     = (p_num_ports > 1) ? $clog2(p_num_ports) : 1,
   localparam int p_msg_nbits    = 3 + p_opaque_nbits + p_len_nbits,
   localparam int p_ptr_nbits    = $clog2(p_depth),
   localparam int p_cnt_nbits    = p_ptr_nbits + 1
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                flush,
   input  logic [p_num_ports-1:0]              in_val,
   output logic [p_num_ports-1:0]              in_rdy,
   input  logic [3*p_num_ports-1:0]            in_type,
   input  logic [p_opaque_nbits*p_num_ports-1:0] in_opaque,
   input  logic [p_len_nbits*p_num_ports-1:0]  in_len,
   input  logic [p_num_ports-1:0]              in_domain,
   output logic                                out_val,
   input  logic                                out_rdy,
   output logic [p_msg_nbits-1:0]              out_msg,
   output logic                                out_domain,
   output logic [p_id_nbits-1:0]               out_port,
   output logic [p_cnt_nbits-1:0]              count
);

   logic [p_msg_nbits-1:0] msg_mem  [p_depth];
   logic                   dom_mem  [p_depth];
   logic [p_id_nbits-1:0]  port_mem [p_depth];

   logic [p_ptr_nbits-1:0] head;
   logic [p_ptr_nbits-1:0] tail;
   logic [p_id_nbits-1:0]  rr;
   logic                   armed;

   logic                   grant_any;
   logic [p_id_nbits-1:0]  grant_idx;
   logic [p_id_nbits-1:0]  rr_next;
   logic [p_msg_nbits-1:0] grant_msg;
   logic                   grant_dom;
   logic                   full;
   logic                   enq;
   logic                   deq;

   assign full = (count == p_cnt_nbits'(p_depth));
   assign deq  = out_val & out_rdy;

   // Round-robin grant search, packing of the winner, and accept decision.
   always_comb begin
      int idx;
      int gi;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < p_num_ports; k++) begin
         idx = (int'(rr) + k) % p_num_ports;
         if (!grant_any && in_val[idx]) begin
            grant_any = 1'b1;
            grant_idx = p_id_nbits'(idx);
         end else begin
            grant_any = grant_any;
         end
      end
      gi        = int'(grant_idx);
      grant_msg = {in_type[3*gi +: 3],
                   in_opaque[p_opaque_nbits*gi +: p_opaque_nbits],
                   in_len[p_len_nbits*gi +: p_len_nbits]};
      grant_dom = in_domain[gi];
      // A full queue can still accept when the head leaves in the same cycle.
      enq = grant_any & armed & !flush & (!full | deq);
      in_rdy = '0;
      if (enq) begin
         in_rdy[grant_idx] = 1'b1;
      end else begin
         in_rdy = '0;
      end
      if (int'(grant_idx) == p_num_ports - 1) begin
         rr_next = '0;
      end else begin
         rr_next = grant_idx + 1'b1;
      end
   end

   // Pointer, occupancy, arbitration-pointer and post-reset arming state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         rr    <= '0;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (enq) rr <= rr_next;
      end
   end

   // Entry storage; occupancy gating makes resetting the array unnecessary.
   always_ff @(posedge clk) begin
      if (enq) begin
         msg_mem[tail]  <= grant_msg;
         dom_mem[tail]  <= grant_dom;
         port_mem[tail] <= grant_idx;
      end
   end

   // Head view is zeroed when empty so no stale high-domain data leaks out.
   assign out_val    = (count != '0);
   assign out_msg    = out_val ? msg_mem[head]  : '0;
   assign out_domain = out_val ? dom_mem[head]  : 1'b0;
   assign out_port   = out_val ? port_mem[head] : '0;

endmodule

// File: tb/tb_plab5_mcore_mem_resp_cmsg_pack_queue.sv
// Directed, table-driven bench for the packed response-control queue
// (defaults: 2 ports, 8-bit opaque, 2-bit len, depth 4).
module tb_plab5_mcore_mem_resp_cmsg_pack_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [1:0]  in_val;
   logic [1:0]  in_rdy;
   logic [5:0]  in_type;
   logic [15:0] in_opaque;
   logic [3:0]  in_len;
   logic [1:0]  in_domain;
   logic        out_val;
   logic        out_rdy;
   logic [12:0] out_msg;
   logic        out_domain;
   logic [0:0]  out_port;
   logic [2:0]  count;

   plab5_mcore_mem_resp_cmsg_pack_queue dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_val(in_val), .in_rdy(in_rdy), .in_type(in_type),
      .in_opaque(in_opaque), .in_len(in_len), .in_domain(in_domain),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
      .out_domain(out_domain), .out_port(out_port), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] t;
      logic [7:0] o;
      logic [1:0] l;
      logic       d;
   } payload_t;

   typedef struct {
      logic [1:0] val;
      logic       rdy;
      logic       fl;
      payload_t   p0;
      payload_t   p1;
      logic [1:0] e_rdy;
      logic       e_val;
      payload_t   e_head;
      logic       e_port;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vq[$];
   int   n_vec;
   int   n_cmp;
   int   n_err;

   function automatic payload_t pl(input logic [2:0] t, input logic [7:0] o,
                                   input logic [1:0] l, input logic d);
      payload_t p;
      p.t = t; p.o = o; p.l = l; p.d = d;
      return p;
   endfunction

   function automatic payload_t qp(input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return pl(kb[2:0], 8'h30 + kb, kb[1:0], kb[0]);
   endfunction

   function automatic logic [12:0] pack(input payload_t p);
      return {p.t, p.o, p.l};
   endfunction

   task automatic add(input logic [1:0] val, input logic rdy, input logic fl,
                      input payload_t p0, input payload_t p1,
                      input logic [1:0] e_rdy, input logic e_val,
                      input payload_t e_head, input logic e_port, input logic [2:0] e_cnt);
      vec_t v;
      v.val = val; v.rdy = rdy; v.fl = fl; v.p0 = p0; v.p1 = p1;
      v.e_rdy = e_rdy; v.e_val = e_val; v.e_head = e_head;
      v.e_port = e_port; v.e_cnt = e_cnt;
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] val, input logic rdy, input logic fl,
                        input payload_t p0, input payload_t p1);
      in_val    = val;
      out_rdy   = rdy;
      flush     = fl;
      in_type   = {p1.t, p0.t};
      in_opaque = {p1.o, p0.o};
      in_len    = {p1.l, p0.l};
      in_domain = {p1.d, p0.d};
   endtask

   payload_t z, a, pa, pb;

   initial begin
      n_vec = 0; n_cmp = 0; n_err = 0;
      z  = pl(3'd0, 8'h00, 2'd0, 1'b0);
      a  = pl(3'd1, 8'h5A, 2'd2, 1'b1);
      pa = pl(3'd2, 8'h11, 2'd1, 1'b0);
      pb = pl(3'd5, 8'h22, 2'd3, 1'b1);

      // single port, latency 1
      add(2'b01, 1'b0, 1'b0, a,  z,  2'b01, 1'b0, z,  1'b0, 3'd0);
      add(2'b00, 1'b1, 1'b0, z,  z,  2'b00, 1'b1, a,  1'b0, 3'd1);
      add(2'b00, 1'b0, 1'b0, z,  z,  2'b00, 1'b0, z,  1'b0, 3'd0);
      // fairness, rr=1 after port 0 was served
      add(2'b11, 1'b1, 1'b0, pa, pb, 2'b10, 1'b0, z,  1'b0, 3'd0);
      add(2'b11, 1'b1, 1'b0, pa, pb, 2'b01, 1'b1, pb, 1'b1, 3'd1);
      add(2'b11, 1'b1, 1'b0, pa, pb, 2'b10, 1'b1, pa, 1'b0, 3'd1);
      add(2'b11, 1'b1, 1'b0, pa, pb, 2'b01, 1'b1, pb, 1'b1, 3'd1);
      add(2'b00, 1'b1, 1'b0, z,  z,  2'b00, 1'b1, pa, 1'b0, 3'd1);
      add(2'b00, 1'b0, 1'b0, z,  z,  2'b00, 1'b0, z,  1'b0, 3'd0);
      // fill to depth, then concurrent enq/deq across wrap
      add(2'b01, 1'b0, 1'b0, qp(0), z, 2'b01, 1'b0, z,     1'b0, 3'd0);
      add(2'b01, 1'b0, 1'b0, qp(1), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd1);
      add(2'b01, 1'b0, 1'b0, qp(2), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd2);
      add(2'b01, 1'b0, 1'b0, qp(3), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd3);
      add(2'b01, 1'b0, 1'b0, qp(4), z, 2'b00, 1'b1, qp(0), 1'b0, 3'd4);
      add(2'b01, 1'b1, 1'b0, qp(4), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd4);
      add(2'b01, 1'b1, 1'b0, qp(5), z, 2'b01, 1'b1, qp(1), 1'b0, 3'd4);
      add(2'b00, 1'b1, 1'b0, z,     z, 2'b00, 1'b1, qp(2), 1'b0, 3'd4);
      add(2'b00, 1'b1, 1'b0, z,     z, 2'b00, 1'b1, qp(3), 1'b0, 3'd3);
      add(2'b00, 1'b1, 1'b0, z,     z, 2'b00, 1'b1, qp(4), 1'b0, 3'd2);
      add(2'b00, 1'b1, 1'b0, z,     z, 2'b00, 1'b1, qp(5), 1'b0, 3'd1);
      add(2'b00, 1'b0, 1'b0, z,     z, 2'b00, 1'b0, z,     1'b0, 3'd0);
      // flush with 3 buffered and a pending input
      add(2'b01, 1'b0, 1'b0, qp(0), z, 2'b01, 1'b0, z,     1'b0, 3'd0);
      add(2'b01, 1'b0, 1'b0, qp(1), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd1);
      add(2'b01, 1'b0, 1'b0, qp(2), z, 2'b01, 1'b1, qp(0), 1'b0, 3'd2);
      add(2'b01, 1'b1, 1'b1, qp(3), z, 2'b00, 1'b1, qp(0), 1'b0, 3'd3);
      add(2'b00, 1'b0, 1'b0, z,     z, 2'b00, 1'b0, z,     1'b0, 3'd0);

      // reset state, including the dead cycle right after release
      reset = 1'b1;
      drive(2'b00, 1'b0, 1'b0, z, z);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(2'b11, 1'b1, 1'b0, pa, pb);
      #1;
      check("rst in_rdy", 32'(in_rdy), 32'h0);
      check("rst out_val", 32'(out_val), 32'h0);
      check("rst count", 32'(count), 32'h0);
      check("rst out_msg", 32'(out_msg), 32'h0);
      reset = 1'b0;
      #1;
      check("post-rst in_rdy", 32'(in_rdy), 32'h0);
      @(posedge clk);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].val, vq[i].rdy, vq[i].fl, vq[i].p0, vq[i].p1);
         #1;
         n_vec++;
         check($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'(vq[i].e_rdy));
         check($sformatf("v%0d out_val", i), 32'(out_val), 32'(vq[i].e_val));
         check($sformatf("v%0d out_msg", i), 32'(out_msg),
               vq[i].e_val ? 32'(pack(vq[i].e_head)) : 32'h0);
         check($sformatf("v%0d out_domain", i), 32'(out_domain),
               vq[i].e_val ? 32'(vq[i].e_head.d) : 32'h0);
         check($sformatf("v%0d out_port", i), 32'(out_port),
               vq[i].e_val ? 32'(vq[i].e_port) : 32'h0);
         check($sformatf("v%0d count", i), 32'(count), 32'(vq[i].e_cnt));
      end

      // anchor the packed layout with a literal
      check("layout", 32'(pack(a)), 32'h056A);

      // async reset between edges with two entries buffered
      @(negedge clk);
      drive(2'b01, 1'b0, 1'b0, qp(1), z);
      @(negedge clk);
      drive(2'b01, 1'b0, 1'b0, qp(3), z);
      @(negedge clk);
      drive(2'b00, 1'b0, 1'b0, z, z);
      #1;
      check("pre-areset count", 32'(count), 32'd2);
      check("pre-areset out_domain", 32'(out_domain), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("areset out_val", 32'(out_val), 32'h0);
      check("areset out_domain", 32'(out_domain), 32'h0);
      check("areset count", 32'(count), 32'h0);
      check("areset out_msg", 32'(out_msg), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b01, 1'b0, 1'b0, qp(2), z);
      #1;
      check("areset release in_rdy", 32'(in_rdy), 32'h0);
      @(posedge clk);
      #1;
      check("areset release count", 32'(count), 32'h0);
      @(negedge clk);
      #1;
      check("armed in_rdy", 32'(in_rdy), 32'h1);
      drive(2'b00, 1'b0, 1'b0, z, z);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
